fifo_rd_arbiter: RTL and testbench



---
 rtl/fifo_rd_arbiter_if.sv | 32 +++
 rtl/fifo_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_arbiter_if.sv
// Read-port bundle between the async FIFO read domain, the arbiter and its consumers.
//   rempty/rdata : FIFO empty flag and combinational read data at raddr
//   rinc         : FIFO pop strobe
//   req/rdy      : per-consumer request (level) and ready-to-accept
//   gnt/dvalid   : one-hot grant and per-consumer data strobe
//   dout         : read data passed through to the consumers
//   burst_done   : one-cycle pulse after a grant is released
// Modport slave is the arbiter side; master is the FIFO/consumer side.
interface fifo_rd_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DSIZE = 8
);
   logic             rempty;
   logic [DSIZE-1:0] rdata;
   logic             rinc;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  rdy;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  dvalid;
   logic [DSIZE-1:0] dout;
   logic             burst_done;

   modport slave (
      input  rempty, rdata, req, rdy,
      output rinc, gnt, dvalid, dout, burst_done
   );

   modport master (
      output rempty, rdata, req, rdy,
      input  rinc, gnt, dvalid, dout, burst_done
   );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing one async-FIFO read port among NREQ consumers.
// One consumer is granted at a time for a burst of at most MAX_BURST pops; the
// grant is released early when the consumer drops req or the FIFO stays empty
// for EMPTY_TIMEOUT consecutive cycles.
// Ports:
//   rclk, rrst_n : read-domain clock, asynchronous active-low reset
//   bus (slave)  : rempty, rdata in; req, rdy in; rinc, gnt, dvalid, dout, burst_done out
// Optional build macro FIFO_RD_ARB_PRIO0_EN: requester 0 wins whenever it
// requests and its grants leave rr_ptr untouched; others stay round-robin.
module fifo_rd_arbiter #(
   parameter int unsigned NREQ          = 4,
   parameter int unsigned DSIZE         = 8,
   parameter int unsigned MAX_BURST     = 8,
   parameter int unsigned EMPTY_TIMEOUT = 4
) (
   input logic              rclk,
   input logic              rrst_n,
   fifo_rd_arbiter_if.slave bus
);
   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW = $clog2(MAX_BURST + 1);
   localparam int unsigned EW = $clog2(EMPTY_TIMEOUT + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [GW-1:0]    gidx_q, gidx_d;
   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]    pop_cnt_q, pop_cnt_d;
   logic [EW-1:0]    empty_cnt_q, empty_cnt_d;
   logic             burst_done_q, burst_done_d;

   logic             rinc;
   logic             found;
   logic [GW-1:0]    pick;
   logic [DSIZE-1:0] dout;

   // Pop only for the granted consumer, and never while the FIFO reads empty.
   assign rinc = (|(gnt_q & bus.req & bus.rdy)) & ~bus.rempty;
   assign dout = bus.rdata;

   assign bus.rinc       = rinc;
   assign bus.gnt        = gnt_q;
   assign bus.dvalid     = gnt_q & {NREQ{rinc}};
   assign bus.dout       = dout;
   assign bus.burst_done = burst_done_q;

   // Circular scan for the first requester at or after rr_ptr.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
`ifdef FIFO_RD_ARB_PRIO0_EN
      if (bus.req[0]) begin
         found = 1'b1;
      end
`endif
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && bus.req[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

   // Next-state and burst bookkeeping.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      gidx_d       = gidx_q;
      rr_ptr_d     = rr_ptr_q;
      pop_cnt_d    = pop_cnt_q;
      empty_cnt_d  = empty_cnt_q;
      burst_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (found && !bus.rempty) begin
               state_d = BURST;
               gnt_d   = NREQ'(1) << pick;
               gidx_d  = pick;
            end
         end

         BURST: begin
            if (rinc) begin
               pop_cnt_d = pop_cnt_q + PW'(1);
            end
            // A stalled consumer with data present does not advance the timeout.
            if (bus.rempty) begin
               empty_cnt_d = empty_cnt_q + EW'(1);
            end else begin
               empty_cnt_d = '0;
            end

            if ((rinc && (pop_cnt_q == PW'(MAX_BURST - 1))) ||
                !bus.req[gidx_q] ||
                (bus.rempty && (empty_cnt_q == EW'(EMPTY_TIMEOUT - 1)))) begin
               state_d      = IDLE;
               gnt_d        = '0;
               pop_cnt_d    = '0;
               empty_cnt_d  = '0;
               burst_done_d = 1'b1;
               rr_ptr_d     = (gidx_q == GW'(NREQ - 1)) ? '0 : gidx_q + GW'(1);
`ifdef FIFO_RD_ARB_PRIO0_EN
               if (gidx_q == '0) begin
                  rr_ptr_d = rr_ptr_q;
               end
`endif
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         gidx_q       <= '0;
         rr_ptr_q     <= '0;
         pop_cnt_q    <= '0;
         empty_cnt_q  <= '0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         gidx_q       <= gidx_d;
         rr_ptr_q     <= rr_ptr_d;
         pop_cnt_q    <= pop_cnt_d;
         empty_cnt_q  <= empty_cnt_d;
         burst_done_q <= burst_done_d;
      end
   end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a queue model of the FIFO supplies rdata
// and a registered rempty; every popped word is checked against a scoreboard of
// (consumer mask, data) entries pushed when the word is loaded.
module tb_fifo_rd_arbiter;
   localparam int unsigned NREQ          = 4;
   localparam int unsigned DSIZE         = 8;
   localparam int unsigned MAX_BURST     = 8;
   localparam int unsigned EMPTY_TIMEOUT = 4;

   typedef struct packed {
      logic [NREQ-1:0]  mask;
      logic [DSIZE-1:0] data;
   } exp_t;

   logic rclk = 1'b0;
   logic rrst_n;

   fifo_rd_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

   fifo_rd_arbiter #(
      .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .EMPTY_TIMEOUT(EMPTY_TIMEOUT)
   ) dut (
      .rclk(rclk),
      .rrst_n(rrst_n),
      .bus(bus)
   );

   always #5 rclk = ~rclk;

   exp_t             sb[$];
   logic [DSIZE-1:0] fifo[$];
   int               n_cmp = 0;
   int               n_err = 0;
   int               pops[NREQ];
   logic             force_empty = 1'b0;
   int               wval = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void upd_fifo();
      bus.rempty = force_empty || (fifo.size() == 0);
      bus.rdata  = (fifo.size() != 0) ? fifo[0] : '0;
   endfunction

   task automatic load(input int cnt, input int cons);
      for (int k = 0; k < cnt; k++) begin
         logic [DSIZE-1:0] w;
         w = DSIZE'(wval * 37 + 11);
         wval++;
         fifo.push_back(w);
         sb.push_back('{mask: NREQ'(1) << cons, data: w});
      end
      upd_fifo();
   endtask

   // One clock cycle: sample at negedge+1, pop the model FIFO after the edge.
   task automatic cyc();
      logic pop;
      #1;
      chk("rinc_while_empty", 32'(bus.rinc & bus.rempty), 32'(0));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'(1));
      chk("dvalid_gating", 32'(bus.dvalid), 32'(bus.rinc ? bus.gnt : '0));
      if (bus.dvalid != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_dvalid", 32'(bus.dvalid), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("dvalid", 32'(bus.dvalid), 32'(e.mask));
            chk("dout", 32'(bus.dout), 32'(e.data));
         end
         for (int i = 0; i < NREQ; i++) pops[i] += int'(bus.dvalid[i]);
      end
      pop = bus.rinc;
      @(posedge rclk);
      #1;
      if (pop && fifo.size() != 0) void'(fifo.pop_front());
      upd_fifo();
      @(negedge rclk);
   endtask

   // Bounded wait for a grant (want_done=0) or a burst_done pulse (want_done=1).
   task automatic wait_for(input bit want_done, input int limit, output int cnt);
      cnt = 0;
      do begin
         cyc();
         cnt++;
      end while (cnt < limit && !(want_done ? (bus.burst_done === 1'b1) : (bus.gnt !== '0)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int base, b2, b3;
      int order[4];
      int order7[2];

      foreach (pops[i]) pops[i] = 0;

      // Reset with requests and data present: nothing may be granted or popped.
      rrst_n  = 1'b0;
      bus.req = '1;
      bus.rdy = '1;
      upd_fifo();
      load(3, 0);
      @(negedge rclk);
      cyc();
      cyc();
      chk("rst_gnt", 32'(bus.gnt), 32'(0));
      chk("rst_rinc", 32'(bus.rinc), 32'(0));
      chk("rst_dvalid", 32'(bus.dvalid), 32'(0));
      chk("rst_done", 32'(bus.burst_done), 32'(0));

      // Single requester, 3 words, then empty timeout.
      rrst_n  = 1'b1;
      bus.req = 4'b0001;
      base    = pops[0];
      wait_for(1'b0, 20, n);
      chk("t1_gnt_lat", 32'(n), 32'(1));
      chk("t1_gnt", 32'(bus.gnt), 32'(4'b0001));
      wait_for(1'b1, 20, n);
      chk("t1_done_lat", 32'(n), 32'(7));
      chk("t1_gnt_rel", 32'(bus.gnt), 32'(0));
      chk("t1_pops", 32'(pops[0] - base), 32'(3));
      chk("t1_sb", 32'(sb.size()), 32'(0));

      // All requesting, 32 words: four full bursts in rotation.
`ifdef FIFO_RD_ARB_PRIO0_EN
      order = '{0, 0, 0, 0};
`else
      order = '{1, 2, 3, 0};
`endif
      bus.req = '1;
      for (int b = 0; b < 4; b++) load(8, order[b]);
      for (int b = 0; b < 4; b++) begin
         base = pops[order[b]];
         wait_for(1'b0, 20, n);
         chk("t2_gnt_gap", 32'(n), 32'(1));
         chk("t2_gnt", 32'(bus.gnt), 32'(NREQ'(1) << order[b]));
         wait_for(1'b1, 20, n);
         chk("t2_done_lat", 32'(n), 32'(MAX_BURST));
         chk("t2_pops", 32'(pops[order[b]] - base), 32'(MAX_BURST));
      end
      chk("t2_sb", 32'(sb.size()), 32'(0));

      // Granted consumer stalls 3 cycles mid-burst.
      bus.req = 4'b0010;
      load(8, 1);
      base = pops[1];
      wait_for(1'b0, 20, n);
      chk("t3_gnt_lat", 32'(n), 32'(1));
      chk("t3_gnt", 32'(bus.gnt), 32'(4'b0010));
      repeat (3) cyc();
      bus.rdy = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_stall_rinc", 32'(bus.rinc), 32'(0));
         chk("t3_stall_gnt", 32'(bus.gnt), 32'(4'b0010));
         chk("t3_stall_pops", 32'(pops[1] - base), 32'(3));
         cyc();
      end
      bus.rdy = '1;
      wait_for(1'b1, 20, n);
      chk("t3_done_lat", 32'(n), 32'(5));
      chk("t3_pops", 32'(pops[1] - base), 32'(8));
      chk("t3_sb", 32'(sb.size()), 32'(0));

      // Request dropped after 2 pops; next requester follows after one idle cycle.
      bus.req = 4'b1100;
      load(2, 2);
      load(4, 3);
      b2 = pops[2];
      b3 = pops[3];
      wait_for(1'b0, 20, n);
      chk("t4_gnt_lat", 32'(n), 32'(1));
      chk("t4_gnt", 32'(bus.gnt), 32'(4'b0100));
      cyc();
      cyc();
      bus.req = 4'b1000;
      #1;
      chk("t4_drop_rinc", 32'(bus.rinc), 32'(0));
      cyc();
      chk("t4_done", 32'(bus.burst_done), 32'(1));
      chk("t4_idle_gnt", 32'(bus.gnt), 32'(0));
      cyc();
      chk("t4_next_gnt", 32'(bus.gnt), 32'(4'b1000));
      chk("t4_done_pulse", 32'(bus.burst_done), 32'(0));
      wait_for(1'b1, 20, n);
      chk("t4_done_lat", 32'(n), 32'(8));
      chk("t4_pops2", 32'(pops[2] - b2), 32'(2));
      chk("t4_pops3", 32'(pops[3] - b3), 32'(4));
      chk("t4_sb", 32'(sb.size()), 32'(0));

      // rempty forced high during a grant: no pops, release after the timeout.
      bus.req = 4'b0001;
      load(4, 0);
      base = pops[0];
      wait_for(1'b0, 20, n);
      chk("t5_gnt_lat", 32'(n), 32'(1));
      chk("t5_gnt", 32'(bus.gnt), 32'(4'b0001));
      force_empty = 1'b1;
      upd_fifo();
      #1;
      chk("t5_rinc", 32'(bus.rinc), 32'(0));
      wait_for(1'b1, 20, n);
      chk("t5_done_lat", 32'(n), 32'(EMPTY_TIMEOUT));
      chk("t5_pops", 32'(pops[0] - base), 32'(0));
      chk("t5_sb", 32'(sb.size()), 32'(4));

      // Reset mid-burst: outputs clear at once, no burst_done, restart at requester 0.
      force_empty = 1'b0;
      upd_fifo();
      wait_for(1'b0, 20, n);
      chk("t6_gnt_lat", 32'(n), 32'(1));
      chk("t6_gnt", 32'(bus.gnt), 32'(4'b0001));
      cyc();
      cyc();
      rrst_n = 1'b0;
      #1;
      chk("t6_rst_gnt", 32'(bus.gnt), 32'(0));
      chk("t6_rst_rinc", 32'(bus.rinc), 32'(0));
      chk("t6_rst_dvalid", 32'(bus.dvalid), 32'(0));
      chk("t6_rst_done", 32'(bus.burst_done), 32'(0));
      chk("t6_pops_pre", 32'(pops[0] - base), 32'(2));
      cyc();
      chk("t6_rst_done1", 32'(bus.burst_done), 32'(0));
      cyc();
      chk("t6_rst_done2", 32'(bus.burst_done), 32'(0));
      rrst_n  = 1'b1;
      bus.req = '1;
      wait_for(1'b0, 20, n);
      chk("t6_regnt_lat", 32'(n), 32'(1));
      chk("t6_regnt", 32'(bus.gnt), 32'(4'b0001));
      wait_for(1'b1, 20, n);
      chk("t6_done_lat", 32'(n), 32'(6));
      chk("t6_pops", 32'(pops[0] - base), 32'(4));
      chk("t6_sb", 32'(sb.size()), 32'(0));

      // Repeated bursts with everyone requesting.
`ifdef FIFO_RD_ARB_PRIO0_EN
      order7 = '{0, 0};
`else
      order7 = '{1, 2};
`endif
      load(8, order7[0]);
      load(8, order7[1]);
      for (int b = 0; b < 2; b++) begin
         wait_for(1'b0, 20, n);
         chk("t7_gnt_gap", 32'(n), 32'(1));
         chk("t7_gnt", 32'(bus.gnt), 32'(NREQ'(1) << order7[b]));
         wait_for(1'b1, 20, n);
         chk("t7_done_lat", 32'(n), 32'(MAX_BURST));
      end
      bus.req = '0;
      cyc();
      cyc();
      chk("t7_idle_gnt", 32'(bus.gnt), 32'(0));
      chk("t7_sb", 32'(sb.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
